// File: rtl/core_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_wb_pkg
// Brief   : Shared load funct3 codes and load-queue entry layout for the
//           core write-back block.
// Rev     : 1.0  initial release
// ============================================================================
package core_wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int LDQ_ENTRY_W = 10;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } ldq_entry_t;

endpackage
`default_nettype wire

// File: rtl/core_wb_ldq.sv
`default_nettype none
// ============================================================================
// Module  : core_wb_ldq
// Brief   : In-order outstanding-load FIFO; exposes per-slot valid/rd for the
//           register busy mask.
// Rev     : 1.0  initial release
// ============================================================================
module core_wb_ldq
    import core_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  ldq_entry_t            push_entry,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output ldq_entry_t            head,
    output logic [DEPTH-1:0]      ent_valid,
    output logic [DEPTH-1:0][4:0] ent_rd
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    ldq_entry_t [DEPTH-1:0] mem_q, mem_d;

    // Occupied slots are always contiguous, so full/empty follow from the valid bits.
    assign full      = &valid_q;
    assign empty     = ~|valid_q;
    assign head      = mem_q[rd_ptr_q];
    assign ent_valid = valid_q;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_rd
            assign ent_rd[i] = mem_q[i].rd;
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q]   = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_writeback.sv
`default_nettype none
// ============================================================================
// Module  : core_writeback
// Brief   : Register-file write initiator merging ALU results and in-order
//           load responses. Optional protocol checker: CORE_WB_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module core_writeback
    import core_wb_pkg::*;
#(
    parameter int LDQ_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        ALU_VALID,
    input  logic [4:0]  ALU_RD,
    input  logic [31:0] ALU_DATA,
    input  logic        LD_ISSUE,
    output logic        LD_ISSUE_READY,
    input  logic [4:0]  LD_ISSUE_RD,
    input  logic [2:0]  LD_FUNCT3,
    input  logic [1:0]  LD_ADDR_LO,
    input  logic        LD_RVALID,
    output logic        LD_RREADY,
    input  logic [31:0] LD_RDATA,
    output logic        AWVALID,
    output logic [4:0]  AWADDR,
    output logic [31:0] WDATA,
    output logic [31:0] BUSY_MASK,
    output logic        ERR
);

    function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_LB:   fmt_load = {{24{b[7]}}, b};
            F3_LBU:  fmt_load = {24'd0, b};
            F3_LH:   fmt_load = {{16{h[15]}}, h};
            F3_LHU:  fmt_load = {16'd0, h};
            F3_LW:   fmt_load = w;
            default: fmt_load = w;
        endcase
    endfunction

    logic                      q_full, q_empty, q_push, q_pop;
    ldq_entry_t                q_head, q_in;
    logic [LDQ_DEPTH-1:0]      q_valid;
    logic [LDQ_DEPTH-1:0][4:0] q_rd;

    logic        skid_valid_q, skid_valid_d;
    logic [4:0]  skid_rd_q, skid_rd_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic        awvalid_q, awvalid_d;
    logic [4:0]  awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        out_is_load_q, out_is_load_d;
    logic        sel_skid, rsp_accept;
    logic [31:0] busy;

    assign q_in.rd      = LD_ISSUE_RD;
    assign q_in.funct3  = LD_FUNCT3;
    assign q_in.addr_lo = LD_ADDR_LO;

    assign LD_ISSUE_READY = ~q_full;
    assign q_push         = LD_ISSUE & ~q_full;
    assign LD_RREADY      = ~q_empty & (~skid_valid_q | ~ALU_VALID);
    assign rsp_accept     = LD_RVALID & LD_RREADY;
    assign q_pop          = rsp_accept;
    assign sel_skid       = ~ALU_VALID & skid_valid_q;

    core_wb_ldq #(
        .DEPTH (LDQ_DEPTH)
    ) u_ldq (
        .clk        (CLK),
        .rst_n      (NRST),
        .push       (q_push),
        .push_entry (q_in),
        .pop        (q_pop),
        .full       (q_full),
        .empty      (q_empty),
        .head       (q_head),
        .ent_valid  (q_valid),
        .ent_rd     (q_rd)
    );

    // ALU wins the write port; the skid absorbs a response while the ALU holds it.
    always_comb begin
        skid_valid_d  = skid_valid_q;
        skid_rd_d     = skid_rd_q;
        skid_data_d   = skid_data_q;
        awvalid_d     = 1'b0;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        out_is_load_d = 1'b0;
        if (ALU_VALID) begin
            awvalid_d = (ALU_RD != 5'd0);
            awaddr_d  = ALU_RD;
            wdata_d   = ALU_DATA;
        end else if (skid_valid_q) begin
            awvalid_d     = (skid_rd_q != 5'd0);
            awaddr_d      = skid_rd_q;
            wdata_d       = skid_data_q;
            out_is_load_d = (skid_rd_q != 5'd0);
        end
        if (sel_skid) begin
            skid_valid_d = 1'b0;
        end
        if (rsp_accept) begin
            skid_valid_d = 1'b1;
            skid_rd_d    = q_head.rd;
            skid_data_d  = fmt_load(q_head.funct3, q_head.addr_lo, LD_RDATA);
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            skid_valid_q  <= 1'b0;
            skid_rd_q     <= '0;
            skid_data_q   <= '0;
            awvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            out_is_load_q <= 1'b0;
        end else begin
            skid_valid_q  <= skid_valid_d;
            skid_rd_q     <= skid_rd_d;
            skid_data_q   <= skid_data_d;
            awvalid_q     <= awvalid_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            out_is_load_q <= out_is_load_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            if (q_valid[i]) busy[q_rd[i]] = 1'b1;
        end
        if (skid_valid_q) busy[skid_rd_q] = 1'b1;
        if (awvalid_q && out_is_load_q) busy[awaddr_q] = 1'b1;
        busy[0] = 1'b0;
    end

    assign AWVALID   = awvalid_q;
    assign AWADDR    = awaddr_q;
    assign WDATA     = wdata_q;
    assign BUSY_MASK = busy;

`ifdef CORE_WB_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (LD_RVALID & q_empty)
              | (LD_ISSUE & q_full)
              | (ALU_VALID & busy[ALU_RD] & (ALU_RD != 5'd0));
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_writeback
// Brief   : Directed self-checking bench for core_writeback.
// Rev     : 1.0  initial release
// ============================================================================
module tb_core_writeback;
    import core_wb_pkg::*;

    logic        CLK = 1'b0;
    logic        NRST;
    logic        ALU_VALID;
    logic [4:0]  ALU_RD;
    logic [31:0] ALU_DATA;
    logic        LD_ISSUE;
    logic        LD_ISSUE_READY;
    logic [4:0]  LD_ISSUE_RD;
    logic [2:0]  LD_FUNCT3;
    logic [1:0]  LD_ADDR_LO;
    logic        LD_RVALID;
    logic        LD_RREADY;
    logic [31:0] LD_RDATA;
    logic        AWVALID;
    logic [4:0]  AWADDR;
    logic [31:0] WDATA;
    logic [31:0] BUSY_MASK;
    logic        ERR;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    core_writeback #(.LDQ_DEPTH(2)) dut (
        .CLK(CLK), .NRST(NRST),
        .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
        .LD_ISSUE(LD_ISSUE), .LD_ISSUE_READY(LD_ISSUE_READY),
        .LD_ISSUE_RD(LD_ISSUE_RD), .LD_FUNCT3(LD_FUNCT3), .LD_ADDR_LO(LD_ADDR_LO),
        .LD_RVALID(LD_RVALID), .LD_RREADY(LD_RREADY), .LD_RDATA(LD_RDATA),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .WDATA(WDATA),
        .BUSY_MASK(BUSY_MASK), .ERR(ERR)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] exp;
    } fmt_vec_t;

    fmt_vec_t vecs[9];

    task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        LD_ISSUE = 1'b1; LD_ISSUE_RD = rd; LD_FUNCT3 = f3; LD_ADDR_LO = lo;
        tick();
        LD_ISSUE = 1'b0;
    endtask

    initial begin
        vecs[0] = '{F3_LB,  2'd3, 32'h80FF_0000, 5'd7,  32'hFFFF_FF80};
        vecs[1] = '{F3_LBU, 2'd3, 32'h80FF_0000, 5'd7,  32'h0000_0080};
        vecs[2] = '{F3_LH,  2'd2, 32'h80FF_0000, 5'd7,  32'hFFFF_80FF};
        vecs[3] = '{F3_LHU, 2'd2, 32'h80FF_0000, 5'd7,  32'h0000_80FF};
        vecs[4] = '{F3_LW,  2'd0, 32'hCAFE_F00D, 5'd12, 32'hCAFE_F00D};
        vecs[5] = '{F3_LB,  2'd0, 32'h0000_007F, 5'd1,  32'h0000_007F};
        vecs[6] = '{F3_LH,  2'd0, 32'h1234_8001, 5'd31, 32'hFFFF_8001};
        vecs[7] = '{3'b011, 2'd1, 32'hA5A5_5A5A, 5'd20, 32'hA5A5_5A5A};
        vecs[8] = '{F3_LBU, 2'd1, 32'h0000_AB00, 5'd2,  32'h0000_00AB};

        NRST = 1'b0;
        ALU_VALID = 1'b1; ALU_RD = 5'd5; ALU_DATA = 32'hDEAD_BEEF;
        LD_ISSUE = 1'b0; LD_ISSUE_RD = '0; LD_FUNCT3 = '0; LD_ADDR_LO = '0;
        LD_RVALID = 1'b0; LD_RDATA = '0;

        // Reset held with ALU traffic present.
        tick(); tick();
        chk("rst_awvalid", {31'd0, AWVALID}, 32'd0);
        chk("rst_awaddr", {27'd0, AWADDR}, 32'd0);
        chk("rst_wdata", WDATA, 32'd0);
        chk("rst_busy", BUSY_MASK, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        chk("rst_rready", {31'd0, LD_RREADY}, 32'd0);
        chk("rst_issue_ready", {31'd0, LD_ISSUE_READY}, 32'd1);
        NRST = 1'b1;
        tick();
        chk("alu_awvalid", {31'd0, AWVALID}, 32'd1);
        chk("alu_awaddr", {27'd0, AWADDR}, 32'd5);
        chk("alu_wdata", WDATA, 32'hDEAD_BEEF);
        ALU_VALID = 1'b0;
        tick();
        chk("idle_awvalid", {31'd0, AWVALID}, 32'd0);
        chk("idle_awaddr_hold", {27'd0, AWADDR}, 32'd5);
        chk("idle_wdata_hold", WDATA, 32'hDEAD_BEEF);

        // Load formatting table: accept, skid, then output.
        for (int i = 0; i < 9; i++) begin
            issue_load(vecs[i].rd, vecs[i].f3, vecs[i].lo);
            chk("fmt_busy_q", BUSY_MASK, 32'd1 << vecs[i].rd);
            LD_RVALID = 1'b1; LD_RDATA = vecs[i].rdata;
            #1;
            chk("fmt_rready", {31'd0, LD_RREADY}, 32'd1);
            tick();
            LD_RVALID = 1'b0; LD_RDATA = '0;
            chk("fmt_awvalid_early", {31'd0, AWVALID}, 32'd0);
            chk("fmt_busy_skid", BUSY_MASK, 32'd1 << vecs[i].rd);
            tick();
            chk("fmt_awvalid", {31'd0, AWVALID}, 32'd1);
            chk("fmt_awaddr", {27'd0, AWADDR}, {27'd0, vecs[i].rd});
            chk("fmt_wdata", WDATA, vecs[i].exp);
            chk("fmt_busy_out", BUSY_MASK, 32'd1 << vecs[i].rd);
            tick();
            chk("fmt_done_awvalid", {31'd0, AWVALID}, 32'd0);
            chk("fmt_done_busy", BUSY_MASK, 32'd0);
        end

        // Two outstanding loads fill the queue; a third issue is dropped.
        issue_load(5'd3, F3_LW, 2'd0);
        issue_load(5'd4, F3_LW, 2'd0);
        chk("full_ready", {31'd0, LD_ISSUE_READY}, 32'd0);
        chk("full_busy", BUSY_MASK, 32'h0000_0018);
        issue_load(5'd9, F3_LW, 2'd0);
        chk("full_busy_after3", BUSY_MASK, 32'h0000_0018);
        LD_RVALID = 1'b1; LD_RDATA = 32'h0000_0333;
        tick();
        LD_RDATA = 32'h0000_0444;
        tick();
        LD_RVALID = 1'b0;
        chk("pair0_awaddr", {27'd0, AWADDR}, 32'd3);
        chk("pair0_wdata", WDATA, 32'h0000_0333);
        chk("pair0_busy", BUSY_MASK, 32'h0000_0018);
        tick();
        chk("pair1_awvalid", {31'd0, AWVALID}, 32'd1);
        chk("pair1_awaddr", {27'd0, AWADDR}, 32'd4);
        chk("pair1_wdata", WDATA, 32'h0000_0444);
        chk("pair1_busy", BUSY_MASK, 32'h0000_0010);
        tick();
        chk("pair_drained_busy", BUSY_MASK, 32'd0);
        chk("pair_drained_rready", {31'd0, LD_RREADY}, 32'd0);
        chk("pair_drained_ready", {31'd0, LD_ISSUE_READY}, 32'd1);

        // Response collides with ALU traffic.
        issue_load(5'd6, F3_LW, 2'd0);
        issue_load(5'd10, F3_LW, 2'd0);
        LD_RVALID = 1'b1; LD_RDATA = 32'h1111_1111;
        ALU_VALID = 1'b1; ALU_RD = 5'd8; ALU_DATA = 32'h2222_2222;
        #1;
        chk("col_rready0", {31'd0, LD_RREADY}, 32'd1);
        tick();
        chk("col_alu_awvalid", {31'd0, AWVALID}, 32'd1);
        chk("col_alu_awaddr", {27'd0, AWADDR}, 32'd8);
        chk("col_alu_wdata", WDATA, 32'h2222_2222);
        chk("col_busy", BUSY_MASK, 32'h0000_0440);
        ALU_RD = 5'd9; ALU_DATA = 32'h3333_3333; LD_RDATA = 32'h4444_4444;
        #1;
        chk("col_rready_blocked", {31'd0, LD_RREADY}, 32'd0);
        tick();
        chk("col_alu2_awaddr", {27'd0, AWADDR}, 32'd9);
        chk("col_alu2_wdata", WDATA, 32'h3333_3333);
        ALU_VALID = 1'b0;
        #1;
        chk("col_rready_open", {31'd0, LD_RREADY}, 32'd1);
        tick();
        LD_RVALID = 1'b0;
        chk("col_ld_awvalid", {31'd0, AWVALID}, 32'd1);
        chk("col_ld_awaddr", {27'd0, AWADDR}, 32'd6);
        chk("col_ld_wdata", WDATA, 32'h1111_1111);
        tick();
        chk("col_ld2_awaddr", {27'd0, AWADDR}, 32'd10);
        chk("col_ld2_wdata", WDATA, 32'h4444_4444);
        tick();
        chk("col_done_awvalid", {31'd0, AWVALID}, 32'd0);
        chk("col_done_busy", BUSY_MASK, 32'd0);

        // Writes to x0 are suppressed; x0 never marks busy.
        ALU_VALID = 1'b1; ALU_RD = 5'd0; ALU_DATA = 32'h5555_5555;
        tick();
        ALU_VALID = 1'b0;
        chk("x0_alu_awvalid", {31'd0, AWVALID}, 32'd0);
        issue_load(5'd0, F3_LW, 2'd0);
        chk("x0_busy_q", BUSY_MASK, 32'd0);
        chk("x0_rready", {31'd0, LD_RREADY}, 32'd1);
        LD_RVALID = 1'b1; LD_RDATA = 32'h6666_6666;
        tick();
        LD_RVALID = 1'b0;
        chk("x0_busy_skid", BUSY_MASK, 32'd0);
        tick();
        chk("x0_ld_awvalid", {31'd0, AWVALID}, 32'd0);
        chk("x0_busy_out", BUSY_MASK, 32'd0);
        chk("x0_drained", {31'd0, LD_RREADY}, 32'd0);

`ifdef CORE_WB_CHECK_EN
        // Stray response sets a sticky error.
        LD_RVALID = 1'b1;
        tick();
        LD_RVALID = 1'b0;
        chk("err_set", {31'd0, ERR}, 32'd1);
        tick(); tick();
        chk("err_sticky", {31'd0, ERR}, 32'd1);
        NRST = 1'b0;
        #1;
        chk("err_reset", {31'd0, ERR}, 32'd0);
        NRST = 1'b1;
`else
        LD_RVALID = 1'b1;
        tick();
        LD_RVALID = 1'b0;
        chk("err_tied", {31'd0, ERR}, 32'd0);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
